// File: rtl/tusca_agregador_clima_pkg.sv
// Shared types for the climate aggregator: FSM encoding, latched channel result
// and the saturating 16-bit helpers used by the level and relay thresholds.
package tusca_agregador_clima_pkg;

  localparam int W_DADO = 16;

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    MEDE     = 3'd1,
    AGUARDA  = 3'd2,
    ATUALIZA = 3'd3,
    AGREGA   = 3'd4,
    ESPERA   = 3'd5
  } estado_t;

  // Result captured while waiting; ok=0 covers erro, pronto+erro and timeout.
  typedef struct packed {
    logic              ok;
    logic [W_DADO-1:0] temp;
    logic [W_DADO-1:0] umid;
  } resultado_t;

  function automatic logic [W_DADO-1:0] soma_sat(input logic [W_DADO-1:0] a,
                                                 input logic [W_DADO-1:0] b);
    logic [W_DADO:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W_DADO] ? '1 : s[W_DADO-1:0];
  endfunction

  function automatic logic [W_DADO-1:0] sub_sat(input logic [W_DADO-1:0] a,
                                                input logic [W_DADO-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/tusca_agregador_clima_histerese_nivel.sv
// Fan level with hysteresis: counts limits crossed going up and (with margin)
// going down, and only moves the held level when one of them demands it.
module histerese_nivel
  import tusca_agregador_clima_pkg::*;
#(
  parameter int               N_NIVEIS  = 8,
  parameter int               W_NIVEL   = $clog2(N_NIVEIS),
  parameter logic [W_DADO-1:0] HIST_TEMP = 16'h0100
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_atualiza,
  input  logic                             i_falha_seg,
  input  logic [W_DADO-1:0]                i_temp,
  input  logic [N_NIVEIS-2:0][W_DADO-1:0]  i_lim_temp,
  output logic [W_NIVEL-1:0]               o_nivel
);

  localparam logic [W_NIVEL-1:0] NIVEL_MAX = W_NIVEL'(N_NIVEIS - 1);

  logic [W_NIVEL-1:0] r_nivel;
  logic [W_NIVEL-1:0] w_up;
  logic [W_NIVEL-1:0] w_dn;
  logic [W_DADO-1:0]  w_temp_hist;

  always_comb begin
    w_up        = '0;
    w_dn        = '0;
    w_temp_hist = soma_sat(i_temp, HIST_TEMP);
    for (int k = 0; k < N_NIVEIS - 1; k++) begin
      if (i_temp >= i_lim_temp[k])      w_up = w_up + W_NIVEL'(1);
      if (w_temp_hist >= i_lim_temp[k]) w_dn = w_dn + W_NIVEL'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_nivel <= '0;
    end else if (i_atualiza) begin
      if (i_falha_seg)          r_nivel <= NIVEL_MAX;
      else if (w_up > r_nivel)  r_nivel <= w_up;
      else if (w_dn < r_nivel)  r_nivel <= w_dn;
    end
  end

  assign o_nivel = r_nivel;

endmodule

// File: rtl/tusca_agregador_clima.sv
// Round-robin scheduler over N DHT11 channels: keeps last good reading per
// channel, flags repeat offenders, aggregates maxima and drives fan/relay.
module tusca_agregador_clima
  import tusca_agregador_clima_pkg::*;
#(
  parameter int                N_CANAIS      = 4,
  parameter int                N_NIVEIS      = 8,
  parameter int                W_NIVEL       = $clog2(N_NIVEIS),
  parameter logic [W_DADO-1:0] HIST_TEMP     = 16'h0100,
  parameter logic [W_DADO-1:0] HIST_UMID     = 16'h0200,
  parameter int                MAX_ERROS     = 3,
  parameter int                PERIODO_DELAY = 100_000_000,
  parameter int                TIMEOUT_CANAL = 50_000_000
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_habilita,
  output logic [N_CANAIS-1:0]              o_medir,
  input  logic [N_CANAIS-1:0]              i_pronto,
  input  logic [N_CANAIS-1:0]              i_erro,
  input  logic [N_CANAIS-1:0][W_DADO-1:0]  i_temperatura,
  input  logic [N_CANAIS-1:0][W_DADO-1:0]  i_umidade,
  input  logic [N_NIVEIS-2:0][W_DADO-1:0]  i_lim_temp,
  input  logic [W_DADO-1:0]                i_lim_umidade,
  output logic [W_NIVEL-1:0]               o_nivel,
  output logic                             o_rele,
  output logic [W_DADO-1:0]                o_temp_max,
  output logic [W_DADO-1:0]                o_umid_max,
  output logic [N_CANAIS-1:0]              o_canal_falho,
  output logic                             o_nova_medida,
  output logic [2:0]                       o_db_estado,
  output logic [2:0]                       o_db_canal
);

  localparam int                W_CH      = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;
  localparam int                W_ERR     = $clog2(MAX_ERROS + 1);
  localparam logic [W_CH-1:0]   ULT_CANAL = W_CH'(N_CANAIS - 1);
  localparam logic [W_ERR-1:0]  ERR_MAX   = W_ERR'(MAX_ERROS);
  localparam logic [31:0]       TMO_FIM   = 32'(TIMEOUT_CANAL - 1);
  localparam logic [31:0]       DLY_FIM   = 32'(PERIODO_DELAY - 1);

  estado_t                         r_estado, w_prox;
  logic [W_CH-1:0]                 r_canal;
  logic [31:0]                     r_timer;
  resultado_t                      r_res;
  logic [W_DADO-1:0]               r_temp_max, r_umid_max;
  logic                            r_rele, r_nova;

  logic [N_CANAIS-1:0]             w_medir;
  logic                            w_timeout, w_delay_fim, w_resposta;
  logic [N_CANAIS-1:0]             w_valido, w_falho, w_saudavel;
  logic [N_CANAIS-1:0][W_DADO-1:0] w_temp, w_umid;
  logic [W_DADO-1:0]               w_tmax, w_umax, w_lim_baixo;
  logic                            w_algum, w_agrega;

  assign w_timeout   = (r_timer == TMO_FIM);
  assign w_delay_fim = (r_timer == DLY_FIM);
  // Only the channel being polled may end the wait; others are ignored.
  assign w_resposta  = i_pronto[r_canal] | i_erro[r_canal];
  assign w_agrega    = (r_estado == AGREGA);

  always_ff @(posedge i_clock) begin
    if (!i_reset) r_estado <= INICIAL;
    else          r_estado <= w_prox;
  end

  always_comb begin
    w_prox  = r_estado;
    w_medir = '0;
    case (r_estado)
      INICIAL:  if (i_habilita) w_prox = MEDE;
      MEDE: begin
        w_medir[r_canal] = 1'b1;
        w_prox           = AGUARDA;
      end
      AGUARDA:  if (w_resposta || w_timeout) w_prox = ATUALIZA;
      ATUALIZA: w_prox = (r_canal == ULT_CANAL) ? AGREGA : MEDE;
      AGREGA:   w_prox = ESPERA;
      ESPERA:   if (w_delay_fim) w_prox = i_habilita ? MEDE : INICIAL;
      default:  w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_canal    <= '0;
      r_timer    <= '0;
      r_res      <= '0;
      r_temp_max <= '0;
      r_umid_max <= '0;
      r_rele     <= 1'b0;
      r_nova     <= 1'b0;
    end else begin
      r_nova <= w_agrega;
      case (r_estado)
        INICIAL: begin
          r_canal <= '0;
          r_timer <= '0;
        end
        MEDE: r_timer <= '0;
        AGUARDA: begin
          r_timer    <= r_timer + 32'd1;
          r_res.ok   <= i_pronto[r_canal] & ~i_erro[r_canal];
          r_res.temp <= i_temperatura[r_canal];
          r_res.umid <= i_umidade[r_canal];
        end
        ATUALIZA: if (r_canal != ULT_CANAL) r_canal <= r_canal + W_CH'(1);
        AGREGA: begin
          r_timer <= '0;
          if (w_algum) begin
            r_temp_max <= w_tmax;
            r_umid_max <= w_umax;
            if (w_umax >= i_lim_umidade)   r_rele <= 1'b1;
            else if (w_umax < w_lim_baixo) r_rele <= 1'b0;
          end else begin
            r_rele <= 1'b0;
          end
        end
        ESPERA: begin
          r_timer <= r_timer + 32'd1;
          if (w_delay_fim) r_canal <= '0;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
    localparam logic [W_CH-1:0] ID = W_CH'(g);
    logic              r_val, r_fal;
    logic [W_ERR-1:0]  r_nerr;
    logic [W_DADO-1:0] r_t, r_u;
    logic              w_sel;

    assign w_sel = (r_estado == ATUALIZA) && (r_canal == ID);

    always_ff @(posedge i_clock) begin
      if (!i_reset) begin
        r_val  <= 1'b0;
        r_fal  <= 1'b0;
        r_nerr <= '0;
        r_t    <= '0;
        r_u    <= '0;
      end else if (w_sel) begin
        if (r_res.ok) begin
          r_val  <= 1'b1;
          r_fal  <= 1'b0;
          r_nerr <= '0;
          r_t    <= r_res.temp;
          r_u    <= r_res.umid;
        end else begin
          if (r_nerr != ERR_MAX) r_nerr <= r_nerr + W_ERR'(1);
          // This error is the one that reaches the limit (or it was already there).
          if (r_nerr >= ERR_MAX - W_ERR'(1)) r_fal <= 1'b1;
        end
      end
    end

    assign w_valido[g] = r_val;
    assign w_falho[g]  = r_fal;
    assign w_temp[g]   = r_t;
    assign w_umid[g]   = r_u;
  end

  assign w_saudavel  = w_valido & ~w_falho;
  assign w_algum     = |w_saudavel;
  assign w_lim_baixo = sub_sat(i_lim_umidade, HIST_UMID);

  always_comb begin
    w_tmax = '0;
    w_umax = '0;
    for (int c = 0; c < N_CANAIS; c++) begin
      if (w_saudavel[c]) begin
        if (w_temp[c] > w_tmax) w_tmax = w_temp[c];
        if (w_umid[c] > w_umax) w_umax = w_umid[c];
      end
    end
  end

  histerese_nivel #(
    .N_NIVEIS  (N_NIVEIS),
    .W_NIVEL   (W_NIVEL),
    .HIST_TEMP (HIST_TEMP)
  ) u_histerese (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_atualiza  (w_agrega),
    .i_falha_seg (~w_algum),
    .i_temp      (w_tmax),
    .i_lim_temp  (i_lim_temp),
    .o_nivel     (o_nivel)
  );

  assign o_medir       = w_medir;
  assign o_rele        = r_rele;
  assign o_temp_max    = r_temp_max;
  assign o_umid_max    = r_umid_max;
  assign o_canal_falho = w_falho;
  assign o_nova_medida = r_nova;
  assign o_db_estado   = r_estado;
  assign o_db_canal    = 3'(r_canal);

endmodule
